// File: rtl/div_goldschmidt_fx_pkg.sv
// Shared constants for the Goldschmidt fixed-point divider: FSM state codes,
// internal precision and the saturation values used on overflow / divide-by-zero.
package fpDivPkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_NORM = 3'd1;
  localparam logic [2:0] ST_ITER = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Guard bits kept beyond WID+FRAC so rounding noise stays far below one quotient LSB
  localparam int GUARD_BITS = 2;

  // Fraction bits carried by N, D and F during the iterations
  function automatic int int_prec(input int wid, input int frac);
    return wid + frac + GUARD_BITS;
  endfunction

  // Wide enough for any supported WID; callers cast down to WID bits
  localparam int SAT_W = 128;

  // Saturated quotient: unsigned max, or signed max/min depending on result sign
  function automatic logic [SAT_W-1:0] sat_q(input int wid, input logic is_sgn, input logic is_neg);
    logic [SAT_W-1:0] one_v;
    one_v = {{(SAT_W-1){1'b0}}, 1'b1};
    if (!is_sgn) return (one_v << wid) - one_v;
    if (is_neg)  return one_v << (wid - 1);
    return (one_v << (wid - 1)) - one_v;
  endfunction

endpackage

// File: rtl/div_goldschmidt_fx_cntlz.sv
// Leading-zero counter; an all-zero input reports W.
module cntlz #(
  parameter int W = 32
) (
  input  logic [W-1:0]         x,
  output logic [$clog2(W+1)-1:0] lz
);

  localparam int LZW = $clog2(W + 1);

  // Scan upward so the highest set bit writes last and wins
  always_comb begin
    lz = LZW'(W);
    for (int i = 0; i < W; i++) begin
      if (x[i]) lz = LZW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/div_goldschmidt_fx.sv
// Goldschmidt fixed-point divider: q = trunc((a << FRAC) / b), signed or unsigned.
// Iterates N/D toward N/1 at WID+FRAC+2 fraction bits, then a one-step remainder
// check makes the truncated quotient exact.
//
// Handshake: ld is sampled only in IDLE while done is low; the operands are
// captured on that edge and busy is high from the next cycle until the edge
// that leaves DONE. done then pulses for one cycle with q/dvByZr/ovf/iters
// valid, and those outputs hold until the next accepted ld completes.
module div_goldschmidt_fx
  import fpDivPkg::*;
#(
  parameter int WID   = 32,
  parameter int FRAC  = 16,
  parameter int MAXIT = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ld,
  input  logic           sgn,
  input  logic [WID-1:0] a,
  input  logic [WID-1:0] b,
  output logic [WID-1:0] q,
  output logic           busy,
  output logic           done,
  output logic           dvByZr,
  output logic           ovf,
  output logic [3:0]     iters
);

  localparam int P   = int_prec(WID, FRAC);   // internal fraction bits
  localparam int NW  = WID + 1 + P;           // N grows up to the quotient (< 2^WID)
  localparam int DW  = P + 2;                 // D <= 1.0, F <= 2.0
  localparam int NPW = NW + DW;
  localparam int DPW = 2 * DW;
  localparam int QW  = WID + FRAC + 2;        // candidate quotient incl. overflow headroom
  localparam int RW  = QW + WID + 1;          // signed remainder
  localparam int LZW = $clog2(WID + 1);
  localparam int SHW = $clog2(P + 2);

  localparam logic [DW-1:0]  ONE_FX  = DW'(1) << P;
  localparam logic [DW-1:0]  TWO_FX  = DW'(2) << P;
  localparam logic [NPW-1:0] HALF_NP = NPW'(1) << (P - 1);
  localparam logic [DPW-1:0] HALF_DP = DPW'(1) << (P - 1);
  localparam logic [QW-1:0]  LIM_U   = (QW'(1) << WID) - QW'(1);
  localparam logic [QW-1:0]  LIM_SP  = (QW'(1) << (WID - 1)) - QW'(1);
  localparam logic [QW-1:0]  LIM_SN  = QW'(1) << (WID - 1);

  logic [2:0]     state;
  logic           sgn_r;
  logic           neg_r;
  logic [WID-1:0] a_mag;
  logic [WID-1:0] b_mag;
  logic [NW-1:0]  n_r;
  logic [DW-1:0]  d_r;
  logic [DW-1:0]  f_r;
  logic [3:0]     it_cnt;
  logic [WID-1:0] res_q;
  logic           res_dz;
  logic           res_ovf;

  logic           accept;
  logic           a_neg_in;
  logic           b_neg_in;
  logic [LZW-1:0] lz;
  logic           pow2;
  logic [SHW-1:0] sh;
  logic [NW-1:0]  n_init;
  logic [DW-1:0]  d_init;
  logic [NW-1:0]  n_next;
  logic [DW-1:0]  d_next;
  logic [3:0]     it_next;
  logic           iter_exit;
  logic [QW-1:0]  qc;
  logic [RW-1:0]  r_val;
  logic [QW-1:0]  q_corr;
  logic [WID-1:0] q_mag;
  logic           fix_ovf;
  logic [WID-1:0] fix_q;

  assign busy     = (state != ST_IDLE);
  assign accept   = (state == ST_IDLE) && ld && !done;
  assign a_neg_in = sgn & a[WID-1];
  assign b_neg_in = sgn & b[WID-1];

  cntlz #(.W(WID)) u_cntlz (
    .x  (b_mag),
    .lz (lz)
  );

  // Normalisation: P > WID, so the divisor always moves left. A power-of-two
  // divisor is placed at exactly 1.0 (F = 1.0), so the first iteration already
  // sees D == 1.0 and exits; every other divisor lands in [0.5, 1).
  assign pow2   = ((b_mag & (b_mag - WID'(1))) == '0);
  assign sh     = SHW'(P - WID) + SHW'(lz) + SHW'(pow2);
  assign n_init = NW'(a_mag) << sh;
  assign d_init = DW'(b_mag) << sh;

  // One Goldschmidt step, products rounded to nearest at P fraction bits
  assign n_next    = NW'((NPW'(n_r) * NPW'(f_r) + HALF_NP) >> P);
  assign d_next    = DW'((DPW'(d_r) * DPW'(f_r) + HALF_DP) >> P);
  assign it_next   = it_cnt + 4'd1;
  assign iter_exit = (d_next == ONE_FX) || (it_next >= 4'(MAXIT));

  // Candidate quotient and its remainder against the exact dividend
  assign qc    = QW'(n_r >> (P - FRAC));
  assign r_val = (RW'(a_mag) << FRAC) - RW'(qc) * RW'(b_mag);

  // Single-step correction of the candidate, then overflow check and sign
  always_comb begin
    q_corr = qc;
    if (r_val[RW-1])                 q_corr = qc - QW'(1);
    else if (r_val >= RW'(b_mag))    q_corr = qc + QW'(1);
  end

  assign q_mag   = q_corr[WID-1:0];
  assign fix_ovf = !sgn_r ? (q_corr > LIM_U) : (neg_r ? (q_corr > LIM_SN) : (q_corr > LIM_SP));
  assign fix_q   = fix_ovf ? WID'(sat_q(WID, sgn_r, neg_r)) : (neg_r ? -q_mag : q_mag);

  // Control FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (accept) state <= (b == '0) ? ST_DONE : ST_NORM;
        ST_NORM: state <= ST_ITER;
        ST_ITER: if (iter_exit) state <= ST_FIX;
        ST_FIX:  state <= ST_DONE;
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Datapath: operand capture, normalisation and iteration registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sgn_r  <= 1'b0;
      neg_r  <= 1'b0;
      a_mag  <= '0;
      b_mag  <= '0;
      n_r    <= '0;
      d_r    <= '0;
      f_r    <= '0;
      it_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          sgn_r  <= sgn;
          neg_r  <= a_neg_in ^ b_neg_in;
          a_mag  <= a_neg_in ? -a : a;
          b_mag  <= b_neg_in ? -b : b;
          it_cnt <= '0;
        end
        ST_NORM: begin
          n_r <= n_init;
          d_r <= d_init;
          f_r <= TWO_FX - d_init;
        end
        ST_ITER: begin
          n_r    <= n_next;
          d_r    <= d_next;
          f_r    <= TWO_FX - d_next;
          it_cnt <= it_next;
        end
        default: ;
      endcase
    end
  end

  // Result staging and the registered outputs published in DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_q   <= '0;
      res_dz  <= 1'b0;
      res_ovf <= 1'b0;
      q       <= '0;
      done    <= 1'b0;
      dvByZr  <= 1'b0;
      ovf     <= 1'b0;
      iters   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (accept) begin
          res_dz  <= (b == '0);
          res_ovf <= 1'b0;
          res_q   <= WID'(sat_q(WID, sgn, a_neg_in));
        end
        ST_FIX: begin
          res_q   <= fix_q;
          res_ovf <= fix_ovf;
        end
        ST_DONE: begin
          q      <= res_q;
          dvByZr <= res_dz;
          ovf    <= res_ovf;
          iters  <= it_cnt;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_goldschmidt_fx.sv
// Bench for div_goldschmidt_fx: directed vectors, reset/abort and held-ld
// control, then random operands checked against an integer-division model.
module tb_div_goldschmidt_fx;

  localparam int WID   = 32;
  localparam int FRAC  = 16;
  localparam int MAXIT = 6;

  logic            clk;
  logic            rst_n;
  logic            ld;
  logic            sgn_i;
  logic [WID-1:0]  a_i;
  logic [WID-1:0]  b_i;
  logic [WID-1:0]  q;
  logic            busy;
  logic            done;
  logic            dvByZr;
  logic            ovf;
  logic [3:0]      iters;

  int n_tests;
  int n_fail;

  logic [WID-1:0] exp_q[$];
  logic [1:0]     exp_f[$];   // {ovf, dvByZr}

  div_goldschmidt_fx #(.WID(WID), .FRAC(FRAC), .MAXIT(MAXIT)) dut (
    .clk    (clk),
    .rst    (rst_n),
    .ld     (ld),
    .sgn    (sgn_i),
    .a      (a_i),
    .b      (b_i),
    .q      (q),
    .busy   (busy),
    .done   (done),
    .dvByZr (dvByZr),
    .ovf    (ovf),
    .iters  (iters)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference: exact integer division of the scaled dividend, then range clamp
  task automatic model(input logic [31:0] av, input logic [31:0] bv, input logic s,
                       output logic [31:0] eq, output logic eo, output logic ez);
    longint num;
    longint den;
    longint quo;
    eo = 1'b0;
    ez = 1'b0;
    if (bv == 32'd0) begin
      ez = 1'b1;
      if (!s)        eq = 32'hFFFF_FFFF;
      else if (av[31]) eq = 32'h8000_0000;
      else           eq = 32'h7FFF_FFFF;
    end else begin
      if (s) begin
        num = longint'($signed(av)) * (longint'(1) << FRAC);
        den = longint'($signed(bv));
      end else begin
        num = longint'({32'd0, av}) * (longint'(1) << FRAC);
        den = longint'({32'd0, bv});
      end
      quo = num / den;
      eq  = quo[31:0];
      if (!s && quo > 64'sd4294967295) begin
        eo = 1'b1; eq = 32'hFFFF_FFFF;
      end else if (s && quo > 64'sd2147483647) begin
        eo = 1'b1; eq = 32'h7FFF_FFFF;
      end else if (s && quo < -64'sd2147483648) begin
        eo = 1'b1; eq = 32'h8000_0000;
      end
    end
  endtask

  // Drive one operation, wait for done (bounded) and score it.
  // exp_k > 0 demands that iteration count; latency is counted to the edge
  // that first samples done high (one after the edge that raises it).
  task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input logic s,
                       input int exp_k, input string tag);
    logic [31:0] eq;
    logic        eo;
    logic        ez;
    logic [31:0] e_q;
    logic [1:0]  e_f;
    int          cyc;
    bit          got;
    model(av, bv, s, eq, eo, ez);
    exp_q.push_back(eq);
    exp_f.push_back({eo, ez});
    @(negedge clk);
    a_i = av; b_i = bv; sgn_i = s; ld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ld = 1'b0;
    check({tag, ":busy"}, 64'(busy), 64'd1);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk);
      cyc++;
      #1;
      if (done === 1'b1) got = 1'b1;
    end
    check({tag, ":done_seen"}, 64'(got), 64'd1);
    e_q = exp_q.pop_front();
    e_f = exp_f.pop_front();
    if (got) begin
      check({tag, ":q"}, 64'(q), 64'(e_q));
      check({tag, ":ovf"}, 64'(ovf), 64'(e_f[1]));
      check({tag, ":dvByZr"}, 64'(dvByZr), 64'(e_f[0]));
      if (e_f[0]) begin
        check({tag, ":iters"}, 64'(iters), 64'd0);
        check({tag, ":lat"}, 64'(cyc + 1), 64'd2);
      end else begin
        check({tag, ":iters_range"}, 64'((iters >= 4'd1) && (iters <= 4'(MAXIT))), 64'd1);
        check({tag, ":lat"}, 64'(cyc + 1), 64'(4 + int'(iters)));
        if (exp_k > 0) check({tag, ":iters"}, 64'(iters), 64'(exp_k));
      end
      @(posedge clk);
      #1;
      check({tag, ":pulse"}, 64'(done), 64'd0);
      check({tag, ":q_hold"}, 64'(q), 64'(e_q));
      check({tag, ":idle"}, 64'(busy), 64'd0);
    end
  endtask

  initial begin
    logic [31:0] eq;
    logic        eo;
    logic        ez;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    int          cyc;
    int          pulses;
    bit          got;

    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0; ld = 1'b0; sgn_i = 1'b0; a_i = '0; b_i = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst:q", 64'(q), 64'd0);
    check("rst:busy", 64'(busy), 64'd0);
    check("rst:done", 64'(done), 64'd0);
    check("rst:dvByZr", 64'(dvByZr), 64'd0);
    check("rst:ovf", 64'(ovf), 64'd0);
    check("rst:iters", 64'(iters), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    do_op(32'h0003_0000, 32'h0001_0000, 1'b0, 1, "three_by_one");
    do_op(32'h0001_0000, 32'h0003_0000, 1'b0, 0, "third");
    do_op(32'hFFFF_0000, 32'h0003_0000, 1'b1, 0, "neg_third");
    do_op(32'h0005_0000, 32'h0000_0000, 1'b0, 0, "dz_u");
    do_op(32'hFFFF_0000, 32'h0000_0000, 1'b1, 0, "dz_s");
    do_op(32'h7FFF_0000, 32'h0000_0001, 1'b0, 0, "ovf_u");
    do_op(32'h8000_0000, 32'hFFFF_0000, 1'b1, 0, "ovf_s_pos");
    do_op(32'h8000_0000, 32'h0001_0000, 1'b1, 0, "min_s_exact");
    do_op(32'h0000_0000, 32'h1234_5678, 1'b1, 0, "zero_div");

    // ld held high through busy with operands changing mid-flight
    model(32'h0007_0000, 32'h0002_0000, 1'b0, eq, eo, ez);
    @(negedge clk);
    a_i = 32'h0007_0000; b_i = 32'h0002_0000; sgn_i = 1'b0; ld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_i = 32'hDEAD_0000; b_i = 32'h0000_0003; sgn_i = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk);
      cyc++;
      #1;
      if (done === 1'b1) got = 1'b1;
    end
    ld = 1'b0;
    check("held:done_seen", 64'(got), 64'd1);
    check("held:q", 64'(q), 64'(eq));
    pulses = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    check("held:single_op", 64'(pulses), 64'd0);

    // Asynchronous reset while iterating aborts the operation
    @(negedge clk);
    a_i = 32'h0001_0000; b_i = 32'h0003_0000; sgn_i = 1'b0; ld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ld = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort:busy", 64'(busy), 64'd0);
    check("abort:q", 64'(q), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) pulses++;
    end
    check("abort:no_done", 64'(pulses), 64'd0);
    do_op(32'h0001_0000, 32'h0003_0000, 1'b0, 0, "post_rst");

    // Random operands over a spread of magnitudes
    for (int i = 0; i < 80; i++) begin
      ra = $urandom >> $urandom_range(0, 31);
      rb = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) rb = 32'd0;
      rs = 1'($urandom_range(0, 1));
      do_op(ra, rb, rs, 0, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
